// File: rtl/ocm_ring_pkg.sv
// ocm_ring_pkg: shared constants for the OCM ring writer.
//   - CSR word addresses
//   - STATUS and CTRL bit positions
package ocm_ring_pkg;

    localparam logic [2:0] CSR_CTRL   = 3'd0;
    localparam logic [2:0] CSR_WR_PTR = 3'd1;
    localparam logic [2:0] CSR_RD_PTR = 3'd2;
    localparam logic [2:0] CSR_STATUS = 3'd3;
    localparam logic [2:0] CSR_THRESH = 3'd4;

    localparam int ST_FULL  = 16;
    localparam int ST_EMPTY = 17;
    localparam int ST_RDERR = 18;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_FLUSH = 1;

endpackage

// File: rtl/ocm_ring_csr.sv
// ocm_ring_csr: CSR slave for the OCM ring writer.
//   Holds enable, rd_ptr, the sticky rd_err bit and (optionally) THRESH/irq,
//   validates consumer read-pointer updates and provides the read mux.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   wr_ptr_i, wr_cmt_i      accept / committed pointers from the write stage
//   flush_clr_i             flush completes this cycle: rd_ptr returns to 0
//   csr_*_i                 CSR slave request
//   csr_readdata_o          read data, valid the cycle after csr_read_i
//   enable_o, flush_req_o   CTRL enable level and flush request pulse
//   full_o                  ring full (accept pointer vs rd_ptr)
//   irq_o                   threshold interrupt (0 unless OCM_RING_IRQ_EN)
// Optional: define OCM_RING_IRQ_EN to include THRESH and the interrupt.
module ocm_ring_csr
    import ocm_ring_pkg::*;
#(
    parameter int RING_LOG2 = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [RING_LOG2:0]   wr_ptr_i,
    input  logic [RING_LOG2:0]   wr_cmt_i,
    input  logic                 flush_clr_i,
    input  logic [2:0]           csr_address_i,
    input  logic                 csr_write_i,
    input  logic                 csr_read_i,
    input  logic [31:0]          csr_writedata_i,
    output logic [31:0]          csr_readdata_o,
    output logic                 enable_o,
    output logic                 flush_req_o,
    output logic                 full_o,
    output logic                 irq_o
);

    localparam int PW = RING_LOG2 + 1;
    localparam logic [PW-1:0] RING_WORDS = {1'b1, {RING_LOG2{1'b0}}};

    logic          enable_q;
    logic [PW-1:0] rd_ptr_q;
    logic          rd_err_q;
    logic [31:0]   readdata_q;

    logic [PW-1:0] count, ccount, wr_value, rd_dist;
    logic          empty, rd_ok;
    logic [31:0]   status, rdata;
    logic          unused_wdata;

    // Modulo 2^(RING_LOG2+1) arithmetic: the extra bit disambiguates full/empty.
    assign count    = wr_ptr_i - rd_ptr_q;
    assign ccount   = wr_cmt_i - rd_ptr_q;
    assign full_o   = (count == RING_WORDS);
    assign empty    = (wr_cmt_i == rd_ptr_q);
    assign wr_value = csr_writedata_i[PW-1:0];
    // A new rd_ptr may not pass wr_cmt nor lag it by more than one ring.
    assign rd_dist  = wr_cmt_i - wr_value;
    assign rd_ok    = (rd_dist <= RING_WORDS);

    assign flush_req_o  = csr_write_i && (csr_address_i == CSR_CTRL) && csr_writedata_i[CTRL_FLUSH];
    assign unused_wdata = ^csr_writedata_i;

    always_comb begin
        status           = '0;
        status[PW-1:0]   = ccount;
        status[ST_FULL]  = full_o;
        status[ST_EMPTY] = empty;
        status[ST_RDERR] = rd_err_q;
    end

`ifdef OCM_RING_IRQ_EN
    logic [31:0] thresh_q;
    logic        irq_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            thresh_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (csr_write_i && (csr_address_i == CSR_THRESH)) thresh_q <= csr_writedata_i;
            irq_q <= (thresh_q != '0) && (32'(ccount) >= thresh_q);
        end
    end
    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (csr_address_i)
            CSR_CTRL:   rdata[CTRL_EN]  = enable_q;
            CSR_WR_PTR: rdata[PW-1:0]   = wr_cmt_i;
            CSR_RD_PTR: rdata[PW-1:0]   = rd_ptr_q;
            CSR_STATUS: rdata           = status;
`ifdef OCM_RING_IRQ_EN
            CSR_THRESH: rdata           = thresh_q;
`endif
            default:    rdata           = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            enable_q   <= 1'b0;
            rd_ptr_q   <= '0;
            rd_err_q   <= 1'b0;
            readdata_q <= '0;
        end else begin
            if (csr_write_i && (csr_address_i == CSR_CTRL)) enable_q <= csr_writedata_i[CTRL_EN];
            if (csr_write_i && (csr_address_i == CSR_STATUS) && csr_writedata_i[ST_RDERR])
                rd_err_q <= 1'b0;
            // A completing flush overrides any concurrent rd_ptr update.
            if (flush_clr_i) begin
                rd_ptr_q <= '0;
            end else if (csr_write_i && (csr_address_i == CSR_RD_PTR)) begin
                if (rd_ok) rd_ptr_q <= wr_value;
                else       rd_err_q <= 1'b1;
            end
            readdata_q <= csr_read_i ? rdata : 32'h0;
        end
    end

    assign enable_o       = enable_q;
    assign csr_readdata_o = readdata_q;

endmodule

// File: rtl/ocm_ring_writer.sv
// ocm_ring_writer: stream-to-OCM ring buffer producer.
//   Accepts a 32-bit valid/ready stream and writes each beat, one per clock,
//   into a circular region of the on-chip memory (port s2). The consumer CPU
//   reads the ring over s1 and tracks progress through the CSR slave.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   in_valid, in_data, in_ready      input stream
//   ocm_*                            memory port master (single-cycle writes)
//   csr_address/write/read/writedata CSR slave request
//   csr_readdata                     CSR read data, 1-cycle latency
//   irq                              threshold interrupt level
// Parameters: ADDR_W, BASE_WORD, RING_LOG2; BASE_WORD + 2**RING_LOG2 must
//   not exceed 2**ADDR_W.
// Optional: define OCM_RING_IRQ_EN to include THRESH and the interrupt.
module ocm_ring_writer
    import ocm_ring_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_WORD = 0,
    parameter int RING_LOG2 = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ocm_address,
    output logic              ocm_chipselect,
    output logic              ocm_write,
    output logic [31:0]       ocm_writedata,
    output logic [3:0]        ocm_byteenable,
    output logic              ocm_clken,
    input  logic [2:0]        csr_address,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              irq
);

    localparam int PW = RING_LOG2 + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     wr_cmt_q, wr_cmt_d;
    logic              flush_pend_q, flush_pend_d;
    logic              wvld_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic enable, flush_req, full, accept, flush_clr;

    assign in_ready  = enable && !full && !flush_pend_q;
    assign accept    = in_valid && in_ready;
    // Flush waits for the in-flight write so the committed pointer never lies.
    assign flush_clr = flush_pend_q && !wvld_q;

    always_comb begin
        wr_ptr_d     = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        wr_cmt_d     = wvld_q ? wr_cmt_q + 1'b1 : wr_cmt_q;
        flush_pend_d = (flush_pend_q && !flush_clr) || flush_req;
        if (flush_clr) begin
            wr_ptr_d = '0;
            wr_cmt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            wr_cmt_q     <= '0;
            flush_pend_q <= 1'b0;
            wvld_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wr_cmt_q     <= wr_cmt_d;
            flush_pend_q <= flush_pend_d;
            wvld_q       <= accept;
            if (accept) begin
                addr_q  <= ADDR_W'(BASE_WORD) + ADDR_W'(wr_ptr_q[RING_LOG2-1:0]);
                wdata_q <= in_data;
            end
        end
    end

    assign ocm_address    = addr_q;
    assign ocm_writedata  = wdata_q;
    assign ocm_chipselect = wvld_q;
    assign ocm_write      = wvld_q;
    assign ocm_byteenable = 4'hF;
    assign ocm_clken      = 1'b1;

    ocm_ring_csr #(
        .RING_LOG2 (RING_LOG2)
    ) u_csr (
        .clk_i           (clk),
        .reset_i         (reset),
        .wr_ptr_i        (wr_ptr_q),
        .wr_cmt_i        (wr_cmt_q),
        .flush_clr_i     (flush_clr),
        .csr_address_i   (csr_address),
        .csr_write_i     (csr_write),
        .csr_read_i      (csr_read),
        .csr_writedata_i (csr_writedata),
        .csr_readdata_o  (csr_readdata),
        .enable_o        (enable),
        .flush_req_o     (flush_req),
        .full_o          (full),
        .irq_o           (irq)
    );

endmodule
